// File: rtl/exe_stage.sv
// exe_stage -- EXE pipeline stage.
//
// Latches the ID->EXE bundle, evaluates the one-hot ALU operation
// (single-cycle multiply, iterative restoring divider), issues the data-RAM
// request, returns the bypass/wake-up bundle to ID and forwards the MEM bundle.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ID_to_EXE_bus[160:0]: instruction bundle from ID
//   ID_to_EXE_valid     : ID offers an instruction
//   EXE_allow_in        : EXE accepts an instruction this cycle
//   MEM_allow_in        : MEM accepts an instruction this cycle
//   EXE_to_MEM_valid    : EXE offers a finished instruction to MEM
//   EXE_to_MEM_bus[76:0]: bundle to MEM
//   EXE_to_BY_bus[39:0] : bypass / wake-up bundle to ID
//   data_sram_*         : data RAM request (enable, byte enables, addr, wdata)
module exe_stage #(
  parameter int DIV_ITER = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [160:0] ID_to_EXE_bus,
  input  logic         ID_to_EXE_valid,
  output logic         EXE_allow_in,
  input  logic         MEM_allow_in,
  output logic         EXE_to_MEM_valid,
  output logic [76:0]  EXE_to_MEM_bus,
  output logic [39:0]  EXE_to_BY_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  localparam int CNT_W = $clog2(DIV_ITER + 1);

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic         exe_valid_reg;
  logic [160:0] bus_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_valid_reg <= 1'b0;
      bus_reg       <= '0;
    end else begin
      if (EXE_allow_in)
        exe_valid_reg <= ID_to_EXE_valid;
      if (ID_to_EXE_valid && EXE_allow_in)
        bus_reg <= ID_to_EXE_bus;
    end
  end

  // Field unpacking
  logic [2:0]  rf_w_data_valid_stage;
  logic        rf_w_en;
  logic        rf_w_data_sel;
  logic [1:0]  ram_wd;
  logic        ram_we;
  logic        ram_en;
  logic [31:0] ram_wdata;
  logic [4:0]  rf_w_addr;
  logic [18:0] alu_op;
  logic [31:0] src2;
  logic [31:0] src1;
  logic [31:0] inst_pc;

  assign rf_w_data_valid_stage = bus_reg[160:158];
  assign rf_w_en               = bus_reg[157];
  assign rf_w_data_sel         = bus_reg[156];
  assign ram_wd                = bus_reg[155:154];
  assign ram_we                = bus_reg[153];
  assign ram_en                = bus_reg[152];
  assign ram_wdata             = bus_reg[151:120];
  assign rf_w_addr             = bus_reg[119:115];
  assign alu_op                = bus_reg[114:96];
  assign src2                  = bus_reg[95:64];
  assign src1                  = bus_reg[63:32];
  assign inst_pc               = bus_reg[31:0];

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  div_state_t       div_state_reg;
  logic [CNT_W-1:0] div_cnt_reg;
  logic [31:0]      div_rem_reg;    // partial remainder
  logic [31:0]      div_quo_reg;    // dividend shifts out the top, quotient shifts in
  logic [31:0]      div_dvs_reg;    // divisor magnitude
  logic             div_neg_q_reg;
  logic             div_neg_r_reg;
  logic [31:0]      div_q_res_reg;
  logic [31:0]      div_r_res_reg;

  logic        is_div;
  logic        div_signed;
  logic        src1_neg;
  logic        src2_neg;
  logic [31:0] src1_abs;
  logic [31:0] src2_abs;

  assign is_div     = |alu_op[18:15];
  assign div_signed = alu_op[15] | alu_op[16];
  assign src1_neg   = div_signed & src1[31];
  assign src2_neg   = div_signed & src2[31];
  assign src1_abs   = src1_neg ? (32'd0 - src1) : src1;
  assign src2_abs   = src2_neg ? (32'd0 - src2) : src2;

  // One restoring step: bring in the next dividend bit and try to subtract.
  // Bit 32 of the trial difference is the borrow (partial remainder < divisor).
  logic [32:0] step_shift;
  logic [32:0] step_trial;
  logic [31:0] step_rem;
  logic [31:0] step_quo;

  assign step_shift = {div_rem_reg, div_quo_reg[31]};
  assign step_trial = step_shift - {1'b0, div_dvs_reg};
  assign step_rem   = step_trial[32] ? step_shift[31:0] : step_trial[31:0];
  assign step_quo   = {div_quo_reg[30:0], ~step_trial[32]};

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state_reg <= DIV_IDLE;
      div_cnt_reg   <= '0;
      div_rem_reg   <= '0;
      div_quo_reg   <= '0;
      div_dvs_reg   <= '0;
      div_neg_q_reg <= 1'b0;
      div_neg_r_reg <= 1'b0;
      div_q_res_reg <= '0;
      div_r_res_reg <= '0;
    end else begin
      case (div_state_reg)
        DIV_IDLE: begin
          if (exe_valid_reg && is_div) begin
            div_state_reg <= DIV_BUSY;
            div_cnt_reg   <= CNT_W'(DIV_ITER);
            div_rem_reg   <= '0;
            div_quo_reg   <= src1_abs;
            div_dvs_reg   <= src2_abs;
            // A zero divisor must yield an all-ones quotient, which the raw
            // restoring loop already produces, so no sign fix-up there.
            div_neg_q_reg <= (src1_neg ^ src2_neg) & (src2 != 32'd0);
            div_neg_r_reg <= src1_neg;
          end
        end
        DIV_BUSY: begin
          div_rem_reg <= step_rem;
          div_quo_reg <= step_quo;
          div_cnt_reg <= div_cnt_reg - 1'b1;
          if (div_cnt_reg == CNT_W'(1)) begin
            div_state_reg <= DIV_DONE;
            div_q_res_reg <= div_neg_q_reg ? (32'd0 - step_quo) : step_quo;
            div_r_res_reg <= div_neg_r_reg ? (32'd0 - step_rem) : step_rem;
          end
        end
        DIV_DONE: begin
          if (MEM_allow_in)
            div_state_reg <= DIV_IDLE;
        end
        default: div_state_reg <= DIV_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [4:0]  shamt;
  logic [63:0] prod_u;
  logic [31:0] mulh_res;
  logic [31:0] op_res [19];
  logic [31:0] alu_result;

  assign shamt  = src2[4:0];
  assign prod_u = {32'd0, src1} * {32'd0, src2};
  // Signed high word from the unsigned product: subtract the other operand
  // once for each operand whose sign bit is set (mod 2^32).
  assign mulh_res = prod_u[63:32] - (src1[31] ? src2 : 32'd0) - (src2[31] ? src1 : 32'd0);

  assign op_res[0]  = src1 + src2;
  assign op_res[1]  = src1 - src2;
  assign op_res[2]  = {31'd0, $signed(src1) < $signed(src2)};
  assign op_res[3]  = {31'd0, src1 < src2};
  assign op_res[4]  = src1 & src2;
  assign op_res[5]  = src1 | src2;
  assign op_res[6]  = ~(src1 | src2);
  assign op_res[7]  = src1 ^ src2;
  assign op_res[8]  = src1 << shamt;
  assign op_res[9]  = src1 >> shamt;
  assign op_res[10] = $signed(src1) >>> shamt;
  assign op_res[11] = src2;
  assign op_res[12] = prod_u[31:0];
  assign op_res[13] = mulh_res;
  assign op_res[14] = prod_u[63:32];
  assign op_res[15] = div_q_res_reg;
  assign op_res[16] = div_r_res_reg;
  assign op_res[17] = div_q_res_reg;
  assign op_res[18] = div_r_res_reg;

  // One-hot select as an AND-OR tree; an all-zero op yields zero.
  always_comb begin
    alu_result = '0;
    for (int i = 0; i < 19; i++) begin
      if (alu_op[i])
        alu_result = alu_result | op_res[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and bundles
  // ---------------------------------------------------------------------------
  logic exe_ready_go;
  logic byp_data_valid;

  assign exe_ready_go     = ~is_div | (div_state_reg == DIV_DONE);
  assign EXE_allow_in     = ~exe_valid_reg | (exe_ready_go & MEM_allow_in);
  assign EXE_to_MEM_valid = exe_valid_reg & exe_ready_go;
  assign byp_data_valid   = rf_w_data_valid_stage[0] & exe_ready_go;

  assign EXE_to_MEM_bus = {rf_w_data_valid_stage, rf_w_en, rf_w_data_sel,
                           ram_wd, ram_en, alu_result, rf_w_addr, inst_pc};

  assign EXE_to_BY_bus = {rf_w_addr, alu_result, byp_data_valid,
                          exe_valid_reg, rf_w_en};

  // ---------------------------------------------------------------------------
  // Data RAM request
  // ---------------------------------------------------------------------------
  // Gating with MEM_allow_in means a stalled store only fires on the cycle
  // it is actually handed to MEM, so it is issued exactly once.
  logic [3:0] we_lane;

  assign data_sram_en   = ram_en & exe_valid_reg & MEM_allow_in;
  assign data_sram_addr = alu_result;
  assign data_sram_we   = we_lane & {4{ram_we & data_sram_en}};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE     = 2'(gi);
    localparam int         HALF_LSB = (gi % 2) * 8;

    assign we_lane[gi] = (ram_wd == 2'b00)
                       | ((ram_wd == 2'b01) & (data_sram_addr[1] == LANE[1]))
                       | ((ram_wd == 2'b10) & (data_sram_addr[1:0] == LANE));

    // Replicate the narrow datum onto every lane it could land in.
    assign data_sram_wdata[gi*8 +: 8] =
        (ram_wd == 2'b01) ? ram_wdata[HALF_LSB +: 8] :
        (ram_wd == 2'b10) ? ram_wdata[7:0]           :
                            ram_wdata[gi*8 +: 8];
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage -- randomized self-checking bench for exe_stage with a
// behavioural arithmetic reference model.
module tb_exe_stage;

  localparam int DIV_ITER = 32;
  localparam int DIV_LAT  = DIV_ITER + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [160:0] ID_to_EXE_bus;
  logic         ID_to_EXE_valid;
  logic         EXE_allow_in;
  logic         MEM_allow_in;
  logic         EXE_to_MEM_valid;
  logic [76:0]  EXE_to_MEM_bus;
  logic [39:0]  EXE_to_BY_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  exe_stage #(.DIV_ITER(DIV_ITER)) dut (
    .clk             (clk),
    .reset           (reset),
    .ID_to_EXE_bus   (ID_to_EXE_bus),
    .ID_to_EXE_valid (ID_to_EXE_valid),
    .EXE_allow_in    (EXE_allow_in),
    .MEM_allow_in    (MEM_allow_in),
    .EXE_to_MEM_valid(EXE_to_MEM_valid),
    .EXE_to_MEM_bus  (EXE_to_MEM_bus),
    .EXE_to_BY_bus   (EXE_to_BY_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  wire [31:0] mem_res  = EXE_to_MEM_bus[68:37];
  wire [31:0] mem_pc   = EXE_to_MEM_bus[31:0];
  wire [31:0] by_res   = EXE_to_BY_bus[34:3];
  wire        by_byp   = EXE_to_BY_bus[2];
  wire        by_valid = EXE_to_BY_bus[1];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [4:0]      sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    sh = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return (sa < sb) ? 32'd1 : 32'd0;
      3:  return (ua < ub) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return a | b;
      6:  return ~(a | b);
      7:  return a ^ b;
      8:  return a << sh;
      9:  return a >> sh;
      10: begin p = 64'(sa >>> sh); return p[31:0]; end
      11: return b;
      12: begin p = ua * ub; return p[31:0]; end
      13: begin p = 64'(sa * sb); return p[63:32]; end
      14: begin p = ua * ub; return p[63:32]; end
      15: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
      16: begin if (b == 32'd0) return a; p = 64'(sa % sb); return p[31:0]; end
      17: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      18: begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_latency(input int op);
    return (op >= 15 && op <= 18) ? DIV_LAT : 0;
  endfunction

  function automatic logic [160:0] mk_bus(input int op, input logic [31:0] s1, input logic [31:0] s2,
                                          input logic [31:0] pc, input logic [1:0] wd,
                                          input logic we, input logic en, input logic [31:0] wdata);
    logic [18:0] oh;
    oh = '0;
    if (op >= 0) oh[op] = 1'b1;
    return {3'b001, 1'b1, 1'b0, wd, we, en, wdata, 5'd3, oh, s2, s1, pc};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      5: return 32'd0 - 32'($urandom_range(1, 40));
      default: return $urandom();
    endcase
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic send(input logic [160:0] bus);
    ID_to_EXE_bus   = bus;
    ID_to_EXE_valid = 1'b1;
    check_val("allow_in_idle", 32'(EXE_allow_in), 32'd1);
    tick();
    ID_to_EXE_valid = 1'b0;
    ID_to_EXE_bus   = 161'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic await_result(input string tag, input int exp_lat, input logic [31:0] exp_res,
                              input logic [31:0] exp_pc);
    int waited;
    waited = 0;
    while (!EXE_to_MEM_valid && waited < 200) begin
      check_val({tag, "_byp_early"}, 32'(by_byp), 32'd0);
      check_val({tag, "_allow_busy"}, 32'(EXE_allow_in), 32'd0);
      tick();
      waited++;
    end
    check_val({tag, "_lat"}, 32'(waited), 32'(exp_lat));
    check_val({tag, "_res"}, mem_res, exp_res);
    check_val({tag, "_pc"}, mem_pc, exp_pc);
    check_val({tag, "_by_res"}, by_res, exp_res);
    check_val({tag, "_byp"}, 32'(by_byp), 32'd1);
    $display("%s: res=%08h cycles=%0d", tag, mem_res, waited);
  endtask

  task automatic run_alu(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] pc;
    pc = $urandom() & 32'hFFFF_FFFC;
    send(mk_bus(op, a, b, pc, 2'b00, 1'b0, 1'b0, 32'd0));
    await_result(tag, exp_latency(op), ref_alu(op, a, b), pc);
    tick();
    check_val({tag, "_drain"}, 32'(EXE_to_MEM_valid), 32'd0);
  endtask

  task automatic run_store(input logic [1:0] wd, input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] wdata, input int stall);
    logic [31:0] addr, exp_wd;
    logic [3:0]  exp_we;
    addr = base + off;
    case (wd)
      2'b00:   begin exp_we = 4'b1111; exp_wd = wdata; end
      2'b01:   begin exp_we = addr[1] ? 4'b1100 : 4'b0011; exp_wd = {2{wdata[15:0]}}; end
      default: begin exp_we = 4'b0001 << addr[1:0]; exp_wd = {4{wdata[7:0]}}; end
    endcase
    MEM_allow_in = (stall == 0);
    send(mk_bus(0, base, off, 32'h0, wd, 1'b1, 1'b1, wdata));
    for (int i = 0; i < stall; i++) begin
      check_val("st_en_stalled", 32'(data_sram_en), 32'd0);
      check_val("st_we_stalled", 32'(data_sram_we), 32'd0);
      tick();
    end
    MEM_allow_in = 1'b1;
    #1;
    check_val("st_en", 32'(data_sram_en), 32'd1);
    check_val("st_we", 32'(data_sram_we), 32'(exp_we));
    check_val("st_wdata", data_sram_wdata, exp_wd);
    check_val("st_addr", data_sram_addr, addr);
    $display("store wd=%0d addr=%08h we=%b wdata=%08h stall=%0d", wd, addr, data_sram_we, data_sram_wdata, stall);
    tick();
    check_val("st_en_once", 32'(data_sram_en), 32'd0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    reset           = 1'b1;
    ID_to_EXE_valid = 1'b0;
    ID_to_EXE_bus   = '0;
    MEM_allow_in    = 1'b1;
    tick();
    tick();
    check_val("rst_allow_in", 32'(EXE_allow_in), 32'd1);
    check_val("rst_to_mem_valid", 32'(EXE_to_MEM_valid), 32'd0);
    check_val("rst_sram_en", 32'(data_sram_en), 32'd0);
    check_val("rst_sram_we", 32'(data_sram_we), 32'd0);
    check_val("rst_by_valid", 32'(by_valid), 32'd0);
    reset = 1'b0;
    tick();
    check_val("post_rst_allow_in", 32'(EXE_allow_in), 32'd1);
    check_val("post_rst_to_mem_valid", 32'(EXE_to_MEM_valid), 32'd0);

    // Back-to-back add / sub
    ID_to_EXE_bus   = mk_bus(0, 32'd5, 32'd7, 32'h100, 2'b00, 1'b0, 1'b0, 32'd0);
    ID_to_EXE_valid = 1'b1;
    tick();
    ID_to_EXE_bus = mk_bus(1, 32'd3, 32'd9, 32'h104, 2'b00, 1'b0, 1'b0, 32'd0);
    check_val("b2b_add_valid", 32'(EXE_to_MEM_valid), 32'd1);
    check_val("b2b_add_res", mem_res, 32'h0000_000C);
    check_val("b2b_allow_in", 32'(EXE_allow_in), 32'd1);
    tick();
    ID_to_EXE_valid = 1'b0;
    check_val("b2b_sub_valid", 32'(EXE_to_MEM_valid), 32'd1);
    check_val("b2b_sub_res", mem_res, 32'hFFFF_FFFA);
    $display("b2b add/sub: res=%08h", mem_res);
    tick();
    check_val("b2b_drain", 32'(EXE_to_MEM_valid), 32'd0);

    // Divide and corner cases
    run_alu("div_m7_2", 15, 32'hFFFF_FFF9, 32'd2);
    run_alu("mod_m7_2", 16, 32'hFFFF_FFF9, 32'd2);
    run_alu("divu_100_0", 17, 32'd100, 32'd0);
    run_alu("modu_100_0", 18, 32'd100, 32'd0);
    run_alu("div_min_m1", 15, 32'h8000_0000, 32'hFFFF_FFFF);
    run_alu("div_neg_0", 15, 32'hFFFF_FFF9, 32'd0);
    run_alu("mod_neg_0", 16, 32'hFFFF_FFF9, 32'd0);

    // Back-to-back divides: second is latched on the DONE->IDLE edge
    send(mk_bus(15, 32'd1000, 32'hFFFF_FFF9, 32'h200, 2'b00, 1'b0, 1'b0, 32'd0));
    ID_to_EXE_bus   = mk_bus(18, 32'd1000, 32'd7, 32'h204, 2'b00, 1'b0, 1'b0, 32'd0);
    ID_to_EXE_valid = 1'b1;
    await_result("b2b_div1", DIV_LAT, ref_alu(15, 32'd1000, 32'hFFFF_FFF9), 32'h200);
    tick();
    ID_to_EXE_valid = 1'b0;
    await_result("b2b_div2", DIV_LAT, ref_alu(18, 32'd1000, 32'd7), 32'h204);
    tick();
    check_val("b2b_div_drain", 32'(EXE_to_MEM_valid), 32'd0);

    // Byte store from the plan, then assorted stores (some under back-pressure)
    run_store(2'b10, 32'h1000, 32'h3, 32'h0000_00AB, 0);
    for (int i = 0; i < 10; i++)
      run_store(2'($urandom_range(0, 2)), $urandom() & 32'hFFFF_FFF0, 32'($urandom_range(0, 15)),
                $urandom(), (i % 3 == 0) ? 3 : 0);

    // Back-pressure during mulhu
    MEM_allow_in = 1'b0;
    send(mk_bus(14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h300, 2'b00, 1'b0, 1'b0, 32'd0));
    ID_to_EXE_bus   = mk_bus(0, 32'd1, 32'd1, 32'h304, 2'b00, 1'b0, 1'b0, 32'd0);
    ID_to_EXE_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_allow_in", 32'(EXE_allow_in), 32'd0);
      check_val("bp_valid", 32'(EXE_to_MEM_valid), 32'd1);
      check_val("bp_res", mem_res, 32'hFFFF_FFFE);
      check_val("bp_pc", mem_pc, 32'h300);
      check_val("bp_sram_en", 32'(data_sram_en), 32'd0);
      tick();
    end
    MEM_allow_in = 1'b1;
    #1;
    check_val("bp_release_allow", 32'(EXE_allow_in), 32'd1);
    tick();
    ID_to_EXE_valid = 1'b0;
    check_val("bp_next_res", mem_res, 32'd2);
    check_val("bp_next_pc", mem_pc, 32'h304);
    $display("backpressure mulhu: next res=%08h", mem_res);
    tick();

    // Reset in the middle of a divide
    send(mk_bus(17, 32'd12345, 32'd67, 32'h400, 2'b00, 1'b0, 1'b0, 32'd0));
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("rstdiv_by_valid", 32'(by_valid), 32'd0);
    check_val("rstdiv_allow_in", 32'(EXE_allow_in), 32'd1);
    check_val("rstdiv_to_mem_valid", 32'(EXE_to_MEM_valid), 32'd0);
    $display("reset mid-divide: EXE_valid=%0d", by_valid);
    run_alu("rstdiv_add", 0, 32'd40, 32'd2);
    run_alu("rstdiv_divu", 17, 32'd12345, 32'd67);

    // Randomized ALU traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op == 19) op = -1;
      run_alu($sformatf("rnd%0d_op%0d", i, op), op, rnd32(), rnd32());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
